// File: rtl/seq_divider4.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider4
// Description : 4-bit unsigned restoring divider, one trial subtraction per
//               clock, with a start/busy/done handshake and a divide-by-zero
//               flag. Division by zero short-circuits straight to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] rem_reg;      // partial remainder R
    logic [3:0] quo_reg;      // quotient / dividend shift register Q
    logic [3:0] dsr_reg;      // latched divisor D
    logic [1:0] cnt;          // iteration counter

    logic [4:0] trial;
    logic [4:0] diff;
    logic [4:0] rem_next;
    logic [3:0] quo_next;
    logic       last_iter;

    // R[4] is always 0 after a committed step (R < D <= 15); it is kept so the
    // register matches the 5-bit trial width but never feeds the datapath.
    logic       unused_rem_msb;
    assign unused_rem_msb = rem_reg[4];

    assign last_iter = (cnt == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; busy and done are pure functions of the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == 4'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One restoring step: shift in next dividend bit, trial-subtract divisor,
    // keep the difference only when no borrow occurred.
    always_comb begin
        trial = {rem_reg[3:0], quo_reg[3]};
        diff  = trial - {1'b0, dsr_reg};
        if (!diff[4]) begin
            rem_next = diff;
            quo_next = {quo_reg[2:0], 1'b1};
        end else begin
            rem_next = trial;
            quo_next = {quo_reg[2:0], 1'b0};
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg     <= 5'd0;
            quo_reg     <= 4'd0;
            dsr_reg     <= 4'd0;
            cnt         <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != 4'd0) begin
                            rem_reg     <= 5'd0;
                            quo_reg     <= dividend;
                            dsr_reg     <= divisor;
                            cnt         <= 2'd0;
                            div_by_zero <= 1'b0;
                        end else begin
                            quotient    <= 4'hF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt     <= cnt + 2'd1;
                    if (last_iter) begin
                        quotient  <= quo_next;
                        remainder <= rem_next[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider4.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider4
// Description : Scoreboard bench for seq_divider4. The driver pushes expected
//               results (plain / and %) at issue time; a monitor pops and
//               compares on every done pulse and checks the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_divider4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor = 4'd0;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    seq_divider4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         done_edge;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    int         busy_lo = 0;
    int         busy_hi = -1;
    logic [3:0] hold_q = 4'd0;
    logic [3:0] hold_r = 4'd0;
    logic       hold_dz = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on done, plus per-cycle handshake/hold checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("quotient", quotient, mon_e.q);
                    check("remainder", remainder, mon_e.r);
                    check("div_by_zero", div_by_zero, mon_e.dz);
                    check("done_latency", edge_cnt, mon_e.done_edge);
                    if (!mon_e.dz) begin
                        check("invariant", int'(quotient) * int'(mon_e.b) + int'(remainder), int'(mon_e.a));
                        check("rem_lt_div", remainder < mon_e.b, 1);
                    end
                    hold_q  = mon_e.q;
                    hold_r  = mon_e.r;
                    hold_dz = mon_e.dz;
                end
            end
            check("busy", busy, (edge_cnt >= busy_lo && edge_cnt <= busy_hi));
            check("done_busy_excl", done & busy, 0);
            check("quotient_hold", quotient, hold_q);
            check("remainder_hold", remainder, hold_r);
            check("dz_hold", div_by_zero, hold_dz);
        end
    end

    // Issue one division at the next edge (caller knows the DUT is idle then),
    // then wait until the earliest edge at which another can be accepted.
    // keep leaves start high; poke fires an ignored start on the 2nd CALC cycle.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit keep, input bit poke);
        exp_t e;
        int   acc;
        int   gap;
        acc      = edge_cnt + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.a = a;
        e.b = b;
        if (b == 4'd0) begin
            e.q = 4'hF; e.r = a; e.dz = 1'b1; e.done_edge = acc;
            gap = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.done_edge = acc + 4;
            gap = 5;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        if (b != 4'd0) begin
            busy_lo = acc;
            busy_hi = acc + 3;
            hold_dz = 1'b0;
        end
        start = keep;
        for (int i = 1; i <= gap; i++) begin
            @(posedge clk); #1;
            if (poke && i == 1) begin
                start = 1'b1; dividend = 4'd1; divisor = 4'd1;
            end
            if (poke && i == 2) start = 1'b0;
        end
    endtask

    initial begin
        int acc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'd13, 4'd3, 1'b0, 1'b0);
        issue(4'd15, 4'd1, 1'b0, 1'b0);
        issue(4'd7, 4'd9, 1'b0, 1'b0);
        issue(4'd0, 4'd5, 1'b0, 1'b0);
        issue(4'd15, 4'd15, 1'b0, 1'b0);
        issue(4'd9, 4'd0, 1'b0, 1'b0);
        issue(4'd6, 4'd2, 1'b0, 1'b0);
        issue(4'd14, 4'd4, 1'b0, 1'b1);

        // Abort an 11/2 during its 3rd CALC cycle.
        acc = edge_cnt + 1;
        start = 1'b1; dividend = 4'd11; divisor = 4'd2;
        @(posedge clk); #1;
        start = 1'b0; busy_lo = acc; busy_hi = acc + 3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; busy_hi = -1;
        hold_q = 4'd0; hold_r = 4'd0; hold_dz = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dz", div_by_zero, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'd10, 4'd3, 1'b0, 1'b0);

        // Random operations, sometimes back-to-back with start held high.
        for (int n = 0; n < 24; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Exhaustive, start held high throughout.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(4'(a), 4'(b), 1'b1, 1'b0);
            end
        end
        start = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
